// File: rtl/link_mon_pkg.sv
// link_mon_pkg: shared types and helpers for link_protocol_monitor
// (optional stall timeout enabled by LINK_MON_STALL_TIMEOUT_EN).
package link_mon_pkg;
  localparam int FLIT_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, SIZE, PAYLOAD} link_state_t;
  typedef logic [FLIT_W_DEF-1:0] flit_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/link_packet_tracker.sv
// link_packet_tracker: one link's framing FSM, hold check and packet counter
// (stall timeout counter added when LINK_MON_STALL_TIMEOUT_EN is defined).
module link_packet_tracker
  import link_mon_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_credit,
  input  logic [FLIT_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_in_packet,
  output logic              o_in_payload,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic              o_err_hold
`ifdef LINK_MON_STALL_TIMEOUT_EN
  ,
  output logic              o_err_stall
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  link_state_t       r_state;
  logic [FLIT_W-1:0] r_rem;
  logic [FLIT_W-1:0] r_prev_data;
  logic              r_prev_stall;
  logic              w_xfer;
  logic              w_stall;
  logic              w_done;
  logic              w_hold_viol;
  assign w_xfer      = i_valid & i_credit;
  assign w_stall     = i_valid & ~i_credit;
  assign w_done      = w_xfer & ((r_state == SIZE && i_data == '0) ||
                                 (r_state == PAYLOAD && r_rem == FLIT_W'(1)));
  assign w_hold_viol = r_prev_stall & (~i_valid | (i_data != r_prev_data));
  assign o_in_packet  = r_state != IDLE;
  assign o_in_payload = r_state == PAYLOAD;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rem        <= '0;
      r_prev_data  <= '0;
      r_prev_stall <= 1'b0;
      o_pkt_cnt    <= '0;
      o_err_hold   <= 1'b0;
    end else begin
      if (w_xfer)
        case (r_state)
          IDLE: r_state <= SIZE;
          SIZE: begin
            r_rem   <= i_data;
            r_state <= (i_data == '0) ? IDLE : PAYLOAD;
          end
          PAYLOAD: begin
            r_rem   <= r_rem - 1'b1;
            r_state <= w_done ? IDLE : PAYLOAD;
          end
          default: r_state <= IDLE;
        endcase
      r_prev_stall <= w_stall;
      r_prev_data  <= i_data;
      // clear dominates a coincident increment or error
      o_pkt_cnt    <= i_clear ? '0 : w_done ? CNT_W'(sat_inc(32'(o_pkt_cnt), 32'(CNT_MAX))) : o_pkt_cnt;
      o_err_hold   <= ~i_clear & (o_err_hold | w_hold_viol);
    end
  end
`ifdef LINK_MON_STALL_TIMEOUT_EN
  localparam int SC_W = $clog2(TIMEOUT + 1);
  logic [SC_W-1:0] r_stall_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      o_err_stall <= 1'b0;
    end else begin
      r_stall_cnt <= w_stall ? ((r_stall_cnt == SC_W'(TIMEOUT)) ? r_stall_cnt : r_stall_cnt + 1'b1) : '0;
      o_err_stall <= ~i_clear & (o_err_stall | (w_stall & (r_stall_cnt >= SC_W'(TIMEOUT - 1))));
    end
  end
`endif
endmodule

// File: rtl/link_protocol_monitor.sv
// link_protocol_monitor: per-link framing/hold monitor plus concurrency check;
// define LINK_MON_STALL_TIMEOUT_EN to add err_stall timeouts.
module link_protocol_monitor
  import link_mon_pkg::*;
#(
  parameter int NPORT      = 5,
  parameter int FLIT_W     = 16,
  parameter int CNT_W      = 16,
  parameter int MAX_ACTIVE = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NPORT-1:0]        i_valid,
  input  logic [NPORT-1:0]        i_credit,
  input  logic [NPORT*FLIT_W-1:0] i_data,
  input  logic                    i_clear,
  output logic [NPORT-1:0]        o_in_packet,
  output logic [NPORT*CNT_W-1:0]  o_pkt_cnt,
  output logic [NPORT-1:0]        o_err_hold,
  output logic                    o_err_active,
`ifdef LINK_MON_STALL_TIMEOUT_EN
  output logic [NPORT-1:0]        o_err_stall,
`endif
  output logic                    o_err_any
);
  logic [NPORT-1:0] w_in_payload;
  logic             w_over;
  genvar g;
  for (g = 0; g < NPORT; g++) begin : g_trk
    link_packet_tracker #(
      .FLIT_W (FLIT_W),
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT)
    ) u_trk (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid[g]),
      .i_credit    (i_credit[g]),
      .i_data      (i_data[g*FLIT_W +: FLIT_W]),
      .i_clear     (i_clear),
      .o_in_packet (o_in_packet[g]),
      .o_in_payload(w_in_payload[g]),
      .o_pkt_cnt   (o_pkt_cnt[g*CNT_W +: CNT_W]),
`ifdef LINK_MON_STALL_TIMEOUT_EN
      .o_err_stall (o_err_stall[g]),
`endif
      .o_err_hold  (o_err_hold[g])
    );
  end
  assign w_over = $countones(w_in_payload) > MAX_ACTIVE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_err_active <= 1'b0;
    else          o_err_active <= ~i_clear & (o_err_active | w_over);
  end
`ifdef LINK_MON_STALL_TIMEOUT_EN
  assign o_err_any = (|o_err_hold) | o_err_active | (|o_err_stall);
`else
  assign o_err_any = (|o_err_hold) | o_err_active;
`endif
endmodule

// File: tb/tb_link_protocol_monitor.sv
// tb_link_protocol_monitor: directed and randomized checks against a packet-position model
// (covers err_stall when LINK_MON_STALL_TIMEOUT_EN is defined).
module tb_link_protocol_monitor;
  import link_mon_pkg::*;
  localparam int NP = 5, FW = 16, CW = 4, MA = 2, TO = 8;
  localparam int CMAX = (1 << CW) - 1;
`ifdef LINK_MON_STALL_TIMEOUT_EN
  localparam int VW = NP * (CW + 3) + 2;
`else
  localparam int VW = NP * (CW + 2) + 2;
`endif
  logic clk = 0, rst_n = 0, clear = 0;
  logic [NP-1:0] valid = '0, credit = '0;
  logic [NP*FW-1:0] data = '0;
  logic [NP-1:0] in_packet, err_hold;
  logic [NP*CW-1:0] pkt_cnt;
  logic err_active, err_any;
`ifdef LINK_MON_STALL_TIMEOUT_EN
  logic [NP-1:0] err_stall;
  wire [VW-1:0] dut_vec = {in_packet, pkt_cnt, err_hold, err_active, err_any, err_stall};
`else
  wire [VW-1:0] dut_vec = {in_packet, pkt_cnt, err_hold, err_active, err_any};
`endif
  int vectors = 0, miscompares = 0;
  int m_pos[NP], m_len[NP], m_cnt[NP], m_sc[NP];
  bit m_hold[NP], m_stall[NP], p_stall[NP], m_act;
  logic [FW-1:0] p_data[NP];

  always #5 clk = ~clk;

  link_protocol_monitor #(.NPORT(NP), .FLIT_W(FW), .CNT_W(CW), .MAX_ACTIVE(MA), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_credit(credit), .i_data(data),
    .i_clear(clear), .o_in_packet(in_packet), .o_pkt_cnt(pkt_cnt), .o_err_hold(err_hold),
    .o_err_active(err_active),
`ifdef LINK_MON_STALL_TIMEOUT_EN
    .o_err_stall(err_stall),
`endif
    .o_err_any(err_any));

  function automatic logic [VW-1:0] model_vec();
    logic [NP-1:0] ip, eh, es;
    logic [NP*CW-1:0] pc;
    logic any;
    any = m_act;
    for (int i = 0; i < NP; i++) begin
      ip[i] = m_pos[i] != 0;
      eh[i] = m_hold[i];
      es[i] = m_stall[i];
      pc[i*CW +: CW] = CW'(m_cnt[i]);
      any |= m_hold[i];
`ifdef LINK_MON_STALL_TIMEOUT_EN
      any |= m_stall[i];
`endif
    end
`ifdef LINK_MON_STALL_TIMEOUT_EN
    return {ip, pc, eh, m_act, any, es};
`else
    return {ip, pc, eh, m_act, any};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_pos[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_sc[i] = 0;
      m_hold[i] = 0; m_stall[i] = 0; p_stall[i] = 0; p_data[i] = '0;
    end
    m_act = 0;
  endtask

  task automatic drive(input int p, input logic v, input logic c, input logic [FW-1:0] d);
    valid[p] = v;
    credit[p] = c;
    data[p*FW +: FW] = d;
  endtask

  // Model advance: a packet is header + size + size payload flits, length known once size is seen
  task automatic tick();
    int act;
    act = 0;
    for (int i = 0; i < NP; i++) if (m_pos[i] >= 2) act++;
    for (int i = 0; i < NP; i++) begin
      logic [FW-1:0] d;
      bit x, h, done;
      d = data[i*FW +: FW];
      x = valid[i] & credit[i];
      h = p_stall[i] && (!valid[i] || d != p_data[i]);
      done = 0;
      if (x) begin
        if (m_pos[i] == 0) m_pos[i] = 1;
        else begin
          if (m_pos[i] == 1) m_len[i] = 2 + int'(d);
          m_pos[i]++;
          done = (m_pos[i] == m_len[i]);
        end
      end
      if (done) begin
        m_pos[i] = 0;
        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
      end
      m_sc[i] = (valid[i] && !credit[i]) ? ((m_sc[i] < TO) ? m_sc[i] + 1 : TO) : 0;
      if (clear) begin
        m_cnt[i] = 0; m_hold[i] = 0; m_stall[i] = 0;
      end else begin
        m_hold[i] |= h;
        m_stall[i] |= (m_sc[i] >= TO);
      end
      p_stall[i] = valid[i] & !credit[i];
      p_data[i] = d;
    end
    m_act = !clear && (m_act || act > MA);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    #2 rst_n = 0;
    valid = '0; credit = '0; data = '0; clear = 0;
    #1 model_reset();
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", dut_vec);
    end
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", dut_vec);
    end
    @(negedge clk) rst_n = 1;
    tick();
    vectors++;
    if (dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL after_reset: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] flits[4];
    flits = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, flits[k]);
      tick();
      vectors++;
      if (dut_vec !== model_vec() || in_packet[0] !== (k < 3)) begin
        miscompares++;
        $display("FAIL single_packet step%0d: got %h want %h", k, dut_vec, model_vec());
      end
    end
    drive(0, 0, 1, '0);
    tick();
    vectors++;
    if (pkt_cnt[CW-1:0] !== CW'(1) || err_any !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL single_packet_cnt: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_zero_size();
    apply_reset();
    drive(2, 1, 1, 16'h0022);
    tick();
    drive(2, 1, 1, 16'h0000);
    tick();
    vectors++;
    if (in_packet[2] !== 1'b0 || pkt_cnt[2*CW +: CW] !== CW'(1) || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL zero_size: got %h want %h", dut_vec, model_vec());
    end
    drive(2, 0, 1, '0);
    tick();
  endtask

  task automatic test_hold();
    apply_reset();
    drive(1, 1, 0, 16'h1234);
    tick();
    vectors++;
    if (err_hold[1] !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL hold_pre: got %h want %h", dut_vec, model_vec());
    end
    drive(1, 1, 0, 16'h5678);
    tick();
    vectors++;
    if (err_hold[1] !== 1'b1 || err_any !== 1'b1 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL hold_set: got %h want %h", dut_vec, model_vec());
    end
    drive(1, 0, 1, '0);
    clear = 1;
    tick();
    clear = 0;
    tick();
    vectors++;
    if (err_hold[1] !== 1'b0 || err_any !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL hold_clear: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic run_active(input logic [NP-1:0] ports, input logic expect_err);
    logic [FW-1:0] flits[6];
    flits = '{16'h0044, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < NP; p++) if (ports[p]) drive(p, 1, 1, flits[k]);
      tick();
      vectors++;
      if (dut_vec !== model_vec() || err_active !== (expect_err && k >= 2)) begin
        miscompares++;
        $display("FAIL active ports=%b step%0d: got %h want %h", ports, k, dut_vec, model_vec());
      end
    end
    valid = '0;
    tick();
  endtask

  task automatic test_active();
    run_active(5'b01011, 1'b1);
    run_active(5'b00011, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] flits[3];
    apply_reset();
    flits = '{16'h0044, 16'h0004, 16'h0001};
    for (int k = 0; k < 3; k++) begin
      drive(4, 1, 1, flits[k]);
      tick();
    end
    apply_reset();
    flits = '{16'h0045, 16'h0001, 16'h0abc};
    for (int k = 0; k < 3; k++) begin
      drive(4, 1, 1, flits[k]);
      tick();
    end
    drive(4, 0, 1, '0);
    tick();
    vectors++;
    if (pkt_cnt[4*CW +: CW] !== CW'(1) || err_hold[4] !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_mid: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int k = 0; k < 2 * (CMAX + 2); k++) begin
      drive(2, 1, 1, (k % 2) ? 16'h0000 : 16'h0077);
      tick();
    end
    vectors++;
    if (pkt_cnt[2*CW +: CW] !== CW'(CMAX) || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL saturate: got %h want %h", dut_vec, model_vec());
    end
    drive(2, 1, 1, 16'h0077);
    tick();
    drive(2, 1, 1, 16'h0000);
    clear = 1;
    tick();
    clear = 0;
    vectors++;
    if (pkt_cnt[2*CW +: CW] !== '0 || in_packet[2] !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL clear_vs_inc: got %h want %h", dut_vec, model_vec());
    end
    drive(2, 0, 1, '0);
    tick();
  endtask

`ifdef LINK_MON_STALL_TIMEOUT_EN
  task automatic test_stall();
    apply_reset();
    for (int k = 0; k < TO - 1; k++) begin
      drive(3, 1, 0, 16'h0033);
      tick();
    end
    drive(3, 1, 1, 16'h0033);
    tick();
    drive(3, 0, 1, '0);
    tick();
    vectors++;
    if (err_stall[3] !== 1'b0 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL stall_short: got %h want %h", dut_vec, model_vec());
    end
    apply_reset();
    for (int k = 0; k < TO; k++) begin
      drive(3, 1, 0, 16'h0033);
      tick();
    end
    vectors++;
    if (err_stall[3] !== 1'b1 || err_any !== 1'b1 || dut_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL stall_timeout: got %h want %h", dut_vec, model_vec());
    end
    drive(3, 1, 1, 16'h0033);
    tick();
    drive(3, 0, 1, '0);
    tick();
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (p_stall[p] && ($urandom % 10) != 0)
          drive(p, 1, ($urandom % 3) == 0, p_data[p]);
        else
          drive(p, ($urandom % 4) != 0, ($urandom % 4) != 0,
                (m_pos[p] != 1 && ($urandom % 8) == 0) ? FW'($urandom) : FW'($urandom_range(0, 3)));
      end
      clear = ($urandom % 40) == 0;
      tick();
      vectors++;
      if (dut_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %h want %h", c, dut_vec, model_vec());
      end
    end
    clear = 0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_zero_size();
    test_hold();
    test_active();
    test_reset_mid();
    test_saturate();
`ifdef LINK_MON_STALL_TIMEOUT_EN
    test_stall();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
